fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo_if.sv | 26 ++
 rtl/fifo.sv | 55 +++++
 tb/tb_fifo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fifo_if.sv
// Handshake bundle between a FIFO and its producer/consumer.
// The master side drives the write request and the read acceptance; the slave side is the FIFO.
interface fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             data_in_vld;
    logic             data_in_rdy;
    logic [WIDTH-1:0] data_out;
    logic             data_out_vld;
    logic             data_out_rdy;
    logic [LW-1:0]    level;

    modport master (
        output data_in, data_in_vld, data_out_rdy,
        input  data_in_rdy, data_out, data_out_vld, level
    );

    modport slave (
        input  data_in, data_in_vld, data_out_rdy,
        output data_in_rdy, data_out, data_out_vld, level
    );
endinterface

// File: rtl/fifo.sv
// Synchronous first-word fall-through FIFO with a word-count level output.
// Ready and valid are derived from the stored level only, so there is no empty bypass.
module fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input logic   clk,
    input logic   rst_n,
    fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             push;
    logic             pop;

    assign bus.data_in_rdy  = (cnt != LW'(DEPTH));
    assign bus.data_out_vld = (cnt != '0);
    assign bus.level        = cnt;
    assign bus.data_out     = bus.data_out_vld ? mem[rd_ptr] : '0;

    assign push = bus.data_in_vld  && bus.data_in_rdy;
    assign pop  = bus.data_out_vld && bus.data_out_rdy;

    // Storage is deliberately left out of reset; the level gate hides stale words.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed sequences plus a random stretch, checked by a queue-based scoreboard.
module tb_fifo;
    localparam int W = 16;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
    fifo #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    int mlevel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decides push/pop from its own level, queues accepted words.
    always @(posedge clk or negedge rst_n) begin
        bit p, q;
        if (!rst_n) begin
            exp_q.delete();
            mlevel = 0;
        end else begin
            p = bus.data_in_vld && (mlevel != D);
            q = bus.data_out_rdy && (mlevel != 0);
            if (q) void'(exp_q.pop_front());
            if (p) exp_q.push_back(bus.data_in);
            mlevel = mlevel + int'(p) - int'(q);
        end
    end

    // Monitor: compares every presented output against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", 32'(bus.level), 32'(mlevel));
            chk("in_rdy", 32'(bus.data_in_rdy), 32'(mlevel != D));
            chk("out_vld", 32'(bus.data_out_vld), 32'(mlevel != 0));
            if (bus.data_out_vld) begin
                if (exp_q.size() == 0) chk("unexpected_word", 32'(bus.data_out), 32'hDEAD_0000);
                else chk("data_out", 32'(bus.data_out), 32'(exp_q[0]));
            end else begin
                chk("data_out_idle", 32'(bus.data_out), 32'h0);
            end
        end
    end

    initial begin
        int n;
        bus.data_in = '0;
        bus.data_in_vld = 1'b0;
        bus.data_out_rdy = 1'b0;

        #1;
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_vld", 32'(bus.data_out_vld), 0);
        chk("rst_rdy", 32'(bus.data_in_rdy), 1);
        chk("rst_data", 32'(bus.data_out), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single word through
        bus.data_in = 16'hA5A5; bus.data_in_vld = 1'b1;
        tick();
        bus.data_in_vld = 1'b0;
        @(negedge clk);
        chk("single_vld", 32'(bus.data_out_vld), 1);
        chk("single_data", 32'(bus.data_out), 32'hA5A5);
        chk("single_level", 32'(bus.level), 1);
        bus.data_out_rdy = 1'b1;
        tick();
        bus.data_out_rdy = 1'b0;
        @(negedge clk);
        chk("single_pop_level", 32'(bus.level), 0);
        chk("single_pop_data", 32'(bus.data_out), 0);

        // fill to full, then a refused 17th word
        for (int i = 1; i <= 16; i++) begin
            bus.data_in = W'(i); bus.data_in_vld = 1'b1;
            tick();
        end
        bus.data_in = 16'h0011;
        @(negedge clk);
        chk("full_level", 32'(bus.level), 16);
        chk("full_rdy", 32'(bus.data_in_rdy), 0);
        tick();
        @(negedge clk);
        chk("refused_level", 32'(bus.level), 16);
        chk("full_head", 32'(bus.data_out), 32'h0001);

        // full with push and pop: only the pop happens
        bus.data_out_rdy = 1'b1;
        tick();
        bus.data_out_rdy = 1'b0; bus.data_in_vld = 1'b0;
        @(negedge clk);
        chk("full_pop_level", 32'(bus.level), 15);
        chk("full_pop_head", 32'(bus.data_out), 32'h0002);

        // drain to 8, then steady push+pop across pointer wraps
        bus.data_out_rdy = 1'b1;
        repeat (7) tick();
        bus.data_out_rdy = 1'b0;
        @(negedge clk);
        chk("lvl8", 32'(bus.level), 8);
        chk("lvl8_head", 32'(bus.data_out), 32'h0009);
        for (int i = 0; i < 40; i++) begin
            bus.data_in = W'(16'h0100 + i); bus.data_in_vld = 1'b1; bus.data_out_rdy = 1'b1;
            tick();
        end
        bus.data_in_vld = 1'b0; bus.data_out_rdy = 1'b0;
        @(negedge clk);
        chk("stream_level", 32'(bus.level), 8);
        chk("stream_head", 32'(bus.data_out), 32'h0120);

        // drain to 5, then asynchronous reset between edges
        bus.data_out_rdy = 1'b1;
        repeat (3) tick();
        bus.data_out_rdy = 1'b0;
        @(negedge clk);
        chk("lvl5", 32'(bus.level), 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(bus.data_out_vld), 0);
        chk("arst_level", 32'(bus.level), 0);
        chk("arst_rdy", 32'(bus.data_in_rdy), 1);
        chk("arst_data", 32'(bus.data_out), 0);
        #1 rst_n = 1'b1;
        bus.data_out_rdy = 1'b1;
        repeat (3) tick();
        bus.data_out_rdy = 1'b0;
        bus.data_in = 16'hBEEF; bus.data_in_vld = 1'b1;
        tick();
        bus.data_in_vld = 1'b0;
        @(negedge clk);
        chk("post_rst_level", 32'(bus.level), 1);
        chk("post_rst_head", 32'(bus.data_out), 32'hBEEF);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            bus.data_in = W'($urandom);
            bus.data_in_vld = 1'($urandom_range(0, 1));
            bus.data_out_rdy = 1'($urandom_range(0, 1));
            tick();
        end

        bus.data_in_vld = 1'b0; bus.data_out_rdy = 1'b1;
        n = 0;
        while (mlevel != 0 && n < 40) begin
            tick();
            n++;
        end
        bus.data_out_rdy = 1'b0;
        @(negedge clk);
        chk("drain_level", 32'(bus.level), 0);
        chk("drain_vld", 32'(bus.data_out_vld), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
